// File: rtl/cr_prefix_detach_strip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cr_prefix_detach_strip                                                     |
// | Strips the prefix-data TLV into PFD memory, checks its CRC-32, forwards    |
// | every other TLV through one register stage.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cr_prefix_detach_strip #(
  parameter logic [7:0] PFD_TYPE = 8'h0B,
  parameter int         DEPTH    = 256,
  localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_sot,
  input  logic          in_eot,
  input  logic [7:0]    in_typ,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          out_sot,
  output logic          out_eot,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  output logic          pfd_done,
  output logic          pfd_err,
  output logic [AW:0]   pfd_words
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_STRIP = 2'd2
  } state_t;

  localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
  localparam logic [31:0] c_crc_poly = 32'hEDB88320;
  localparam logic [31:0] c_crc_init = 32'hFFFF_FFFF;

  state_t        r_state;
  logic [AW:0]   r_addr;
  logic [31:0]   r_crc;
  logic          r_ovf;
  logic          r_out_valid;
  logic [63:0]   r_out_data;
  logic          r_out_sot;
  logic          r_out_eot;
  logic          r_mem_wr;
  logic [AW-1:0] r_mem_addr;
  logic [63:0]   r_mem_wdata;
  logic          r_pfd_done;
  logic          r_pfd_err;
  logic [AW:0]   r_pfd_words;

  logic          w_in_ready;
  logic          w_accept;
  logic [31:0]   w_crc_next;

  // Reflected CRC-32 over one 64-bit word, bit 0 of byte 0 first.
  function automatic logic [31:0] f_crc_word(input logic [31:0] crc, input logic [63:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ c_crc_poly;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // The output register is always empty while stripping, so STRIP never stalls.
  assign w_in_ready = (r_state == S_STRIP) ? 1'b1 : (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_crc_next = f_crc_word(r_crc, in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_crc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sot   <= 1'b0;
      r_out_eot   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pfd_done  <= 1'b0;
      r_pfd_err   <= 1'b0;
      r_pfd_words <= '0;
    end else begin
      r_mem_wr   <= 1'b0;
      r_pfd_done <= 1'b0;
      r_pfd_err  <= 1'b0;
      if (out_ready) r_out_valid <= 1'b0;

      if (w_accept) begin
        if (in_sot) begin
          // A header inside a PFD aborts it with an error, then starts afresh.
          if (r_state == S_STRIP) begin
            r_pfd_done  <= 1'b1;
            r_pfd_err   <= 1'b1;
            r_pfd_words <= r_addr;
          end
          if (in_typ == PFD_TYPE) begin
            if (in_eot) begin
              r_pfd_done  <= 1'b1;
              r_pfd_err   <= 1'b1;
              r_pfd_words <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_addr  <= '0;
              r_crc   <= c_crc_init;
              r_ovf   <= 1'b0;
              r_state <= S_STRIP;
            end
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_sot   <= 1'b1;
            r_out_eot   <= in_eot;
            r_state     <= in_eot ? S_IDLE : S_FWD;
          end
        end else if (r_state == S_STRIP) begin
          if (in_eot) begin
            r_pfd_done  <= 1'b1;
            r_pfd_err   <= r_ovf | (~r_crc != in_data[31:0]);
            r_pfd_words <= r_addr;
            r_state     <= S_IDLE;
          end else if (r_addr < c_depth) begin
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_addr[AW-1:0];
            r_mem_wdata <= in_data;
            r_addr      <= r_addr + (AW+1)'(1);
            r_crc       <= w_crc_next;
          end else begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_out_valid <= 1'b1;
          r_out_data  <= in_data;
          r_out_sot   <= 1'b0;
          r_out_eot   <= in_eot;
          if (r_state == S_FWD && in_eot) r_state <= S_IDLE;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sot   = r_out_sot;
  assign out_eot   = r_out_eot;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pfd_done  = r_pfd_done;
  assign pfd_err   = r_pfd_err;
  assign pfd_words = r_pfd_words;

endmodule
`default_nettype wire
